// File: rtl/mips_run_ctrl_if.sv
// Host-side streams of the MIPS run controller: program load in, register dump out.
interface mips_run_ctrl_if;
   logic        load_valid;
   logic        load_ready;
   logic [31:0] load_data;
   logic        load_last;
   logic        dump_valid;
   logic        dump_ready;
   logic [4:0]  dump_idx;
   logic [31:0] dump_data;
   logic        dump_last;

   modport master (
      output load_valid, load_data, load_last, dump_ready,
      input  load_ready, dump_valid, dump_idx, dump_data, dump_last
   );

   modport slave (
      input  load_valid, load_data, load_last, dump_ready,
      output load_ready, dump_valid, dump_idx, dump_data, dump_last
   );
endinterface

// File: rtl/mips_run_ctrl.sv
// Run controller for the single-cycle MIPS core: program load, reset/clock-enable
// sequencing for a bounded run, and register-file dump.
module mips_run_ctrl #(
   parameter int unsigned IMEM_DEPTH = 256,
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned CYC_W      = 16
) (
   input  logic              clk,
   input  logic              rst,
   mips_run_ctrl_if.slave    host,
   input  logic              start,
   input  logic [CYC_W-1:0]  max_cycles,
   input  logic [31:0]       halt_pc,
   input  logic [31:0]       cpu_pc,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_waddr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rst,
   output logic              cpu_clk_en,
   output logic [4:0]        rf_raddr,
   input  logic [31:0]       rf_rdata,
   output logic              busy,
   output logic              done,
   output logic [CYC_W-1:0]  cycles,
   output logic [1:0]        halt_reason,
   output logic [ADDR_W:0]   load_count,
   output logic              load_ovf
);

   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_CPURST, S_RUN, S_DUMP, S_DONE
   } state_t;

   state_t              state, state_d;
   logic [ADDR_W-1:0]   wptr, wptr_d;
   logic [CNT_W-1:0]    count_d;
   logic                ovf_d;
   logic [CYC_W-1:0]    cycles_d;
   logic [1:0]          reason_d;
   logic [CYC_W-1:0]    max_q, max_d;
   logic [31:0]         halt_q, halt_d;
   logic                rcnt, rcnt_d;
   logic [4:0]          idx, idx_d;

   logic                load_ready_c;
   logic                dump_valid_c;
   logic                cpu_rst_c;
   logic                clk_en_c;
   logic                halt_hit;
   logic                limit_hit;

   // State and result registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         wptr        <= '0;
         load_count  <= '0;
         load_ovf    <= 1'b0;
         cycles      <= '0;
         halt_reason <= 2'b00;
         max_q       <= '0;
         halt_q      <= '0;
         rcnt        <= 1'b0;
         idx         <= '0;
      end else begin
         state       <= state_d;
         wptr        <= wptr_d;
         load_count  <= count_d;
         load_ovf    <= ovf_d;
         cycles      <= cycles_d;
         halt_reason <= reason_d;
         max_q       <= max_d;
         halt_q      <= halt_d;
         rcnt        <= rcnt_d;
         idx         <= idx_d;
      end
   end

   assign halt_hit  = (cpu_pc == halt_q);
   assign limit_hit = (cycles == max_q);

   // Next-state and strobe decode.
   always_comb begin
      state_d      = state;
      wptr_d       = wptr;
      count_d      = load_count;
      ovf_d        = load_ovf;
      cycles_d     = cycles;
      reason_d     = halt_reason;
      max_d        = max_q;
      halt_d       = halt_q;
      rcnt_d       = rcnt;
      idx_d        = idx;
      load_ready_c = 1'b0;
      dump_valid_c = 1'b0;
      cpu_rst_c    = 1'b0;
      clk_en_c     = 1'b0;
      imem_we      = 1'b0;
      imem_waddr   = wptr;
      imem_wdata   = host.load_data;

      unique case (state)
         S_IDLE, S_DONE: begin
            load_ready_c = 1'b1;
            if (host.load_valid) begin
               // A new program always starts at word 0; a coincident start is dropped.
               imem_we    = 1'b1;
               imem_waddr = '0;
               wptr_d     = ADDR_W'(1);
               count_d    = CNT_W'(1);
               ovf_d      = 1'b0;
               state_d    = host.load_last ? S_IDLE : S_LOAD;
            end else if (start) begin
               max_d    = max_cycles;
               halt_d   = halt_pc;
               cycles_d = '0;
               reason_d = 2'b00;
               rcnt_d   = 1'b0;
               state_d  = S_CPURST;
            end
         end

         S_LOAD: begin
            load_ready_c = 1'b1;
            if (host.load_valid) begin
               imem_we = 1'b1;
               wptr_d  = wptr + ADDR_W'(1);
               count_d = load_count + CNT_W'(1);
               if (host.load_last) begin
                  state_d = S_IDLE;
               end else if (wptr == LAST_ADDR) begin
                  ovf_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end

         S_CPURST: begin
            cpu_rst_c = 1'b1;
            rcnt_d    = 1'b1;
            if (rcnt) begin
               state_d = S_RUN;
            end
         end

         S_RUN: begin
            // Halt PC freezes the core before the instruction at it executes.
            clk_en_c = !halt_hit && !limit_hit;
            if (clk_en_c) begin
               cycles_d = (cycles == '1) ? cycles : cycles + CYC_W'(1);
            end else begin
               reason_d = halt_hit ? 2'b01 : 2'b10;
               idx_d    = '0;
               state_d  = S_DUMP;
            end
         end

         S_DUMP: begin
            dump_valid_c = 1'b1;
            if (host.dump_ready) begin
               idx_d = idx + 5'd1;
               if (idx == 5'd31) begin
                  state_d = S_DONE;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign host.load_ready = load_ready_c;
   assign host.dump_valid = dump_valid_c;
   assign host.dump_idx   = idx;
   assign host.dump_data  = rf_rdata;
   assign host.dump_last  = dump_valid_c && (idx == 5'd31);

   assign rf_raddr   = idx;
   assign cpu_rst    = cpu_rst_c;
   assign cpu_clk_en = clk_en_c;
   assign busy       = (state != S_IDLE) && (state != S_DONE);
   assign done       = (state == S_DONE);

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Self-checking bench for mips_run_ctrl: loads, bounded runs and register dumps
// against a behavioural model of the load, run-length and dump rules.
module tb_mips_run_ctrl;

   localparam int unsigned DEPTH  = 8;
   localparam int unsigned AW     = 3;
   localparam int unsigned CW     = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [CW-1:0] max_cycles;
   logic [31:0]   halt_pc;
   logic [31:0]   cpu_pc;
   logic          imem_we;
   logic [AW-1:0] imem_waddr;
   logic [31:0]   imem_wdata;
   logic          cpu_rst;
   logic          cpu_clk_en;
   logic [4:0]    rf_raddr;
   logic [31:0]   rf_rdata;
   logic          busy;
   logic          done;
   logic [CW-1:0] cycles;
   logic [1:0]    halt_reason;
   logic [AW:0]   load_count;
   logic          load_ovf;

   logic [31:0]   rf [32];
   logic [31:0]   words [16];

   int checks = 0;
   int errors = 0;
   int en_cnt = 0;
   int rst_cnt = 0;
   int ld_pos = 0;
   int ld_cnt = 0;
   bit ld_ovf = 1'b0;

   mips_run_ctrl_if hif ();

   mips_run_ctrl #(.IMEM_DEPTH(DEPTH), .ADDR_W(AW), .CYC_W(CW)) dut (
      .clk         (clk),
      .rst         (rst),
      .host        (hif.slave),
      .start       (start),
      .max_cycles  (max_cycles),
      .halt_pc     (halt_pc),
      .cpu_pc      (cpu_pc),
      .imem_we     (imem_we),
      .imem_waddr  (imem_waddr),
      .imem_wdata  (imem_wdata),
      .cpu_rst     (cpu_rst),
      .cpu_clk_en  (cpu_clk_en),
      .rf_raddr    (rf_raddr),
      .rf_rdata    (rf_rdata),
      .busy        (busy),
      .done        (done),
      .cycles      (cycles),
      .halt_reason (halt_reason),
      .load_count  (load_count),
      .load_ovf    (load_ovf)
   );

   always #5 clk = ~clk;

   assign rf_rdata = rf[rf_raddr];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: sample core controls mid-cycle, then advance the core PC model.
   task automatic step();
      logic r;
      logic e;
      @(negedge clk);
      r = cpu_rst;
      e = cpu_clk_en;
      if (e) en_cnt++;
      if (r) rst_cnt++;
      @(posedge clk);
      #1;
      if (r) cpu_pc = 32'h0;
      else if (e) cpu_pc = cpu_pc + 32'd4;
   endtask

   task automatic load_words(input int n, input bit with_last, input int sb);
      for (int i = 0; i < n; i++) begin
         hif.load_valid = 1'b1;
         hif.load_data  = words[i];
         hif.load_last  = with_last && (i == n - 1);
         start          = (i == sb);
         if (ld_pos == 0) begin
            ld_cnt = 0;
            ld_ovf = 1'b0;
         end
         #2;
         check("load_ready", 32'(hif.load_ready), 32'd1);
         check("imem_we", 32'(imem_we), 32'd1);
         check("imem_waddr", 32'(imem_waddr), 32'(ld_pos));
         check("imem_wdata", imem_wdata, words[i]);
         ld_cnt++;
         ld_pos++;
         if (hif.load_last || ld_pos == int'(DEPTH)) begin
            ld_ovf = !hif.load_last;
            ld_pos = 0;
         end
         step();
         check("load_count", 32'(load_count), 32'(ld_cnt));
         check("load_ovf", 32'(load_ovf), 32'(ld_ovf));
         check("load_busy", 32'(busy), 32'(ld_pos != 0));
         check("load_no_run", 32'(cpu_rst), 32'd0);
      end
      hif.load_valid = 1'b0;
      hif.load_last  = 1'b0;
      start          = 1'b0;
      #2;
      check("idle_we", 32'(imem_we), 32'd0);
      step();
   endtask

   task automatic run_prog(input logic [CW-1:0] mx, input logic [31:0] hp);
      int exp_c;
      logic [1:0] exp_r;
      int n;
      // Core advances one word per enabled cycle from PC 0.
      if (hp[1:0] == 2'b00 && (hp >> 2) <= 32'(mx)) begin
         exp_c = int'(hp >> 2);
         exp_r = 2'b01;
      end else begin
         exp_c = int'(mx);
         exp_r = 2'b10;
      end
      max_cycles = mx;
      halt_pc    = hp;
      start      = 1'b1;
      #2;
      check("start_cycle_rst", 32'(cpu_rst), 32'd0);
      step();
      start      = 1'b0;
      max_cycles = CW'($urandom);
      halt_pc    = $urandom;
      en_cnt     = 0;
      rst_cnt    = 0;
      #2;
      check("cpurst1_rst", 32'(cpu_rst), 32'd1);
      check("cpurst1_en", 32'(cpu_clk_en), 32'd0);
      check("cpurst1_busy", 32'(busy), 32'd1);
      check("cpurst1_cycles", 32'(cycles), 32'd0);
      check("cpurst1_reason", 32'(halt_reason), 32'd0);
      step();
      #2;
      check("cpurst2_rst", 32'(cpu_rst), 32'd1);
      step();
      #2;
      check("first_run_en", 32'(cpu_clk_en), 32'(exp_c > 0));
      check("first_run_rst", 32'(cpu_rst), 32'd0);
      n = 0;
      while (!hif.dump_valid && n < 400) begin
         step();
         n++;
      end
      check("run_timeout", 32'(n < 400), 32'd1);
      check("run_en_count", 32'(en_cnt), 32'(exp_c));
      check("run_rst_count", 32'(rst_cnt), 32'd2);
      check("run_cycles", 32'(cycles), 32'(exp_c));
      check("run_reason", 32'(halt_reason), 32'(exp_r));
      check("dump_en", 32'(cpu_clk_en), 32'd0);
      check("dump_rst", 32'(cpu_rst), 32'd0);
   endtask

   task automatic dump_regs();
      int beat;
      int n;
      bit tog;
      beat = 0;
      n    = 0;
      tog  = 1'b0;
      while (beat < 32 && n < 200) begin
         tog = !tog;
         hif.dump_ready = tog;
         #2;
         check("dump_valid", 32'(hif.dump_valid), 32'd1);
         check("dump_idx", 32'(hif.dump_idx), 32'(beat));
         check("dump_data", hif.dump_data, rf[beat]);
         check("dump_last", 32'(hif.dump_last), 32'(beat == 31));
         check("dump_frozen", 32'(cpu_clk_en), 32'd0);
         step();
         if (tog) beat++;
         n++;
      end
      hif.dump_ready = 1'b0;
      check("dump_beats", 32'(beat), 32'd32);
      #2;
      check("done_flag", 32'(done), 32'd1);
      check("done_busy", 32'(busy), 32'd0);
      check("done_valid", 32'(hif.dump_valid), 32'd0);
      check("done_ready", 32'(hif.load_ready), 32'd1);
      step();
   endtask

   task automatic fill_rf();
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
   endtask

   initial begin
      rst            = 1'b0;
      start          = 1'b0;
      max_cycles     = '0;
      halt_pc        = '0;
      cpu_pc         = 32'h0;
      hif.load_valid = 1'b0;
      hif.load_data  = '0;
      hif.load_last  = 1'b0;
      hif.dump_ready = 1'b0;
      fill_rf();
      for (int i = 0; i < 16; i++) words[i] = $urandom;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_load_ready", 32'(hif.load_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_cycles", 32'(cycles), 32'd0);
      check("rst_reason", 32'(halt_reason), 32'd0);
      check("rst_count", 32'(load_count), 32'd0);
      check("rst_ovf", 32'(load_ovf), 32'd0);
      check("rst_cpu_rst", 32'(cpu_rst), 32'd0);
      check("rst_en", 32'(cpu_clk_en), 32'd0);
      check("rst_dump_valid", 32'(hif.dump_valid), 32'd0);
      rst = 1'b1;
      step();

      // Directed program, start coinciding with the first beat
      words[0] = 32'h20080005;
      words[1] = 32'h20090003;
      words[2] = 32'h01095020;
      words[3] = 32'hAC0A0050;
      load_words(4, 1'b1, 0);

      // Nine beats without last: truncation at depth, then a fresh load
      for (int i = 0; i < 16; i++) words[i] = $urandom;
      load_words(9, 1'b0, 2);
      words[0] = $urandom;
      load_words(1, 1'b1, -1);

      // Random loads, including one exactly filling memory with last
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 16; i++) words[i] = $urandom;
         load_words((k == 0) ? int'(DEPTH) : int'($urandom_range(1, DEPTH)), 1'b1,
                    int'($urandom_range(1, 4)));
      end

      // Directed runs
      fill_rf();
      run_prog(CW'(40), 32'hFFFF_FFF1);
      dump_regs();
      fill_rf();
      run_prog(CW'(40), 32'h0000_001C);
      dump_regs();
      fill_rf();
      run_prog(CW'(7), 32'h0000_001C);
      dump_regs();
      fill_rf();
      run_prog(CW'(0), 32'h0000_0100);
      dump_regs();

      // Load from DONE, then random runs
      for (int i = 0; i < 16; i++) words[i] = $urandom;
      load_words(3, 1'b1, -1);
      for (int k = 0; k < 4; k++) begin
         logic [CW-1:0] mx;
         logic [31:0]   hp;
         mx = CW'($urandom_range(0, 60));
         if ($urandom_range(0, 1) == 1) hp = 32'($urandom_range(0, 70)) << 2;
         else hp = $urandom | 32'h1;
         fill_rf();
         run_prog(mx, hp);
         dump_regs();
      end

      // Reset in the fifth RUN cycle
      load_words(2, 1'b1, -1);
      max_cycles = CW'(40);
      halt_pc    = 32'hFFFF_FFF1;
      start      = 1'b1;
      step();
      start = 1'b0;
      repeat (2) step();
      repeat (4) step();
      check("pre_rst_en", 32'(cpu_clk_en), 32'd1);
      check("pre_rst_cycles", 32'(cycles), 32'd4);
      rst = 1'b0;
      #1;
      check("midrun_en", 32'(cpu_clk_en), 32'd0);
      check("midrun_busy", 32'(busy), 32'd0);
      check("midrun_cycles", 32'(cycles), 32'd0);
      check("midrun_reason", 32'(halt_reason), 32'd0);
      check("midrun_count", 32'(load_count), 32'd0);
      check("midrun_ready", 32'(hif.load_ready), 32'd1);
      check("midrun_cpu_rst", 32'(cpu_rst), 32'd0);
      @(posedge clk);
      #1;
      rst    = 1'b1;
      ld_pos = 0;
      ld_cnt = 0;
      ld_ovf = 1'b0;
      step();
      check("post_rst_busy", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
